gas_id_tnn1_tnnzew: RTL and testbench



---
 rtl/gas_id_tnn1_pkg.sv | 83 ++++++++
 rtl/gas_id_tnn1_tnnzew_argmax.sv | 45 ++++
 rtl/gas_id_tnn1_tnnzew.sv | 89 ++++++++
 tb/tb_gas_id_tnn1_tnnzew.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gas_id_tnn1_pkg.sv
// Shared constants, ternary encoding and the fixed network weights for the
// gas-identification ternary classifier.
package gas_id_tnn1_pkg;
  localparam int FEAT_CNT   = 128;
  localparam int HIDDEN_CNT = 40;
  localparam int FEAT_BITS  = 4;
  localparam int CLASS_CNT  = 6;
  localparam int ACC_BITS   = 12;
  localparam int SCORE_BITS = 7;
  localparam int CLS_BITS   = $clog2(CLASS_CNT);
  localparam int STEP_DONE  = FEAT_CNT + HIDDEN_CNT;
  localparam int STEP_BITS  = $clog2(STEP_DONE + 1);
  localparam int DATA_BITS  = FEAT_BITS * FEAT_CNT;
  localparam int W1_BITS    = 2 * HIDDEN_CNT * FEAT_CNT;
  localparam int THR_BITS   = ACC_BITS * HIDDEN_CNT;
  localparam int W2_BITS    = 2 * CLASS_CNT * HIDDEN_CNT;

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b11;

  function automatic logic [31:0] prng_next(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  function automatic logic [1:0] prng_tern(input logic [31:0] r);
    case (r % 32'd3)
      32'd0:   return T_ZERO;
      32'd1:   return T_POS;
      default: return T_NEG;
    endcase
  endfunction

  // Trained-weight stand-ins, regenerated deterministically at elaboration.
  function automatic logic [W1_BITS-1:0] gen_w1();
    logic [W1_BITS-1:0] w;
    logic [31:0] s;
    w = '0;
    s = 32'h1234_5678;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      for (int f = 0; f < FEAT_CNT; f++) begin
        s = prng_next(s);
        w[2*(h*FEAT_CNT+f) +: 2] = prng_tern(s);
      end
    end
    return w;
  endfunction

  function automatic logic [THR_BITS-1:0] gen_thr();
    logic [THR_BITS-1:0] t;
    logic [31:0] s;
    t = '0;
    s = 32'h0BAD_F00D;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      s = prng_next(s);
      t[ACC_BITS*h +: ACC_BITS] = ACC_BITS'(s[5:0]) - ACC_BITS'(32);
    end
    return t;
  endfunction

  function automatic logic [W2_BITS-1:0] gen_w2();
    logic [W2_BITS-1:0] w;
    logic [31:0] s;
    w = '0;
    s = 32'hC0FF_EE11;
    for (int c = 0; c < CLASS_CNT; c++) begin
      for (int h = 0; h < HIDDEN_CNT; h++) begin
        s = prng_next(s);
        w[2*(c*HIDDEN_CNT+h) +: 2] = prng_tern(s);
      end
    end
    return w;
  endfunction

  localparam logic [W1_BITS-1:0]  W1_DEFAULT  = gen_w1();
  localparam logic [THR_BITS-1:0] THR_DEFAULT = gen_thr();
  localparam logic [W2_BITS-1:0]  W2_DEFAULT  = gen_w2();
endpackage

// File: rtl/gas_id_tnn1_tnnzew_argmax.sv
// gas_id_argmax: combinational comparator tree over the class scores,
// returning the lowest class index when scores tie.
module gas_id_argmax
  import gas_id_tnn1_pkg::*;
(
  input  logic [CLASS_CNT*SCORE_BITS-1:0] i_scores,
  output logic [CLS_BITS-1:0]             o_idx
);
  localparam int LEAVES = 1 << CLS_BITS;
  localparam logic [SCORE_BITS-1:0] S_MIN = {1'b1, {(SCORE_BITS-1){1'b0}}};

  logic [LEAVES*SCORE_BITS-1:0] w_pad;
  logic signed [SCORE_BITS-1:0] w_v0 [LEAVES];
  logic signed [SCORE_BITS-1:0] w_v1 [LEAVES/2];
  logic signed [SCORE_BITS-1:0] w_v2 [LEAVES/4];
  logic [CLS_BITS-1:0]          w_i0 [LEAVES];
  logic [CLS_BITS-1:0]          w_i1 [LEAVES/2];
  logic [CLS_BITS-1:0]          w_i2 [LEAVES/4];

  // Padding leaves sit to the right and carry the minimum score, so they never win.
  assign w_pad = {{(LEAVES-CLASS_CNT){S_MIN}}, i_scores};

  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      w_v0[i] = w_pad[SCORE_BITS*i +: SCORE_BITS];
      w_i0[i] = CLS_BITS'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < LEAVES/2; i++) begin
      w_v1[i] = (w_v0[2*i+1] > w_v0[2*i]) ? w_v0[2*i+1] : w_v0[2*i];
      w_i1[i] = (w_v0[2*i+1] > w_v0[2*i]) ? w_i0[2*i+1] : w_i0[2*i];
    end
  end

  always_comb begin
    for (int i = 0; i < LEAVES/4; i++) begin
      w_v2[i] = (w_v1[2*i+1] > w_v1[2*i]) ? w_v1[2*i+1] : w_v1[2*i];
      w_i2[i] = (w_v1[2*i+1] > w_v1[2*i]) ? w_i1[2*i+1] : w_i1[2*i];
    end
  end

  assign o_idx = (w_v2[1] > w_v2[0]) ? w_i2[1] : w_i2[0];
endmodule

// File: rtl/gas_id_tnn1_tnnzew.sv
// Ternary two-layer classifier: feature-serial hidden layer, hidden-serial
// class scoring, then argmax. Runs once per reset and then holds its result.
module gas_id_tnn1_tnnzew
  import gas_id_tnn1_pkg::*;
#(
  parameter logic [W1_BITS-1:0]  W1  = W1_DEFAULT,
  parameter logic [THR_BITS-1:0] THR = THR_DEFAULT,
  parameter logic [W2_BITS-1:0]  W2  = W2_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  output logic [CLS_BITS-1:0]  prediction
);
  localparam logic signed [SCORE_BITS-1:0] S_ONE  = SCORE_BITS'(1);
  localparam logic signed [SCORE_BITS-1:0] S_MONE = -SCORE_BITS'(1);

  logic [STEP_BITS-1:0]          r_step;
  logic signed [ACC_BITS-1:0]    r_acc [HIDDEN_CNT];
  logic signed [SCORE_BITS-1:0]  r_sc  [CLASS_CNT];
  logic signed [ACC_BITS-1:0]    w_acc_d [HIDDEN_CNT];
  logic signed [SCORE_BITS-1:0]  w_sc_d  [CLASS_CNT];
  logic [HIDDEN_CNT-1:0]         w_hid;
  logic [CLASS_CNT*SCORE_BITS-1:0] w_sc_flat;
  logic                          w_l1;
  logic                          w_l2;

  assign w_l1 = r_step < STEP_BITS'(FEAT_CNT);
  assign w_l2 = !w_l1 && (r_step < STEP_BITS'(STEP_DONE));

  // Weight tests are on parameters, so zero weights produce no datapath at all.
  always_comb begin
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      w_acc_d[h] = '0;
      for (int f = 0; f < FEAT_CNT; f++) begin
        if (w_l1 && (r_step == STEP_BITS'(f))) begin
          if (W1[2*(h*FEAT_CNT+f) +: 2] == T_POS)
            w_acc_d[h] = ACC_BITS'(data[FEAT_BITS*f +: FEAT_BITS]);
          else if (W1[2*(h*FEAT_CNT+f) +: 2] == T_NEG)
            w_acc_d[h] = -ACC_BITS'(data[FEAT_BITS*f +: FEAT_BITS]);
        end
      end
    end
  end

  // Accumulators are frozen after layer 1, so the hidden bits stay stable throughout layer 2.
  always_comb begin
    w_hid = '0;
    for (int h = 0; h < HIDDEN_CNT; h++)
      w_hid[h] = r_acc[h] >= $signed(THR[ACC_BITS*h +: ACC_BITS]);
  end

  always_comb begin
    for (int c = 0; c < CLASS_CNT; c++) begin
      w_sc_d[c] = '0;
      for (int j = 0; j < HIDDEN_CNT; j++) begin
        if (w_l2 && (r_step == STEP_BITS'(FEAT_CNT + j))) begin
          if (W2[2*(c*HIDDEN_CNT+j) +: 2] == T_POS)
            w_sc_d[c] = w_hid[j] ? S_ONE : S_MONE;
          else if (W2[2*(c*HIDDEN_CNT+j) +: 2] == T_NEG)
            w_sc_d[c] = w_hid[j] ? S_MONE : S_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
      for (int h = 0; h < HIDDEN_CNT; h++) r_acc[h] <= '0;
      for (int c = 0; c < CLASS_CNT; c++) r_sc[c] <= '0;
    end else begin
      if (r_step != STEP_BITS'(STEP_DONE)) r_step <= r_step + STEP_BITS'(1);
      for (int h = 0; h < HIDDEN_CNT; h++) r_acc[h] <= r_acc[h] + w_acc_d[h];
      for (int c = 0; c < CLASS_CNT; c++) r_sc[c] <= r_sc[c] + w_sc_d[c];
    end
  end

  always_comb begin
    w_sc_flat = '0;
    for (int c = 0; c < CLASS_CNT; c++)
      w_sc_flat[SCORE_BITS*c +: SCORE_BITS] = r_sc[c];
  end

  gas_id_argmax u_argmax (
    .i_scores (w_sc_flat),
    .o_idx    (prediction)
  );
endmodule

// File: tb/tb_gas_id_tnn1_tnnzew.sv
// Bench: four DUT copies (default and directed weight sets) share one stimulus
// stream; a plain-arithmetic network model supplies the expected predictions.
module tb_gas_id_tnn1_tnnzew;
  import gas_id_tnn1_pkg::*;

  function automatic logic [W2_BITS-1:0] mk_w2_t2();
    logic [W2_BITS-1:0] w;
    w = '0;
    for (int c = 0; c < CLASS_CNT; c++)
      for (int h = 0; h < HIDDEN_CNT; h++)
        w[2*(c*HIDDEN_CNT+h) +: 2] = (c == 2) ? T_POS : T_NEG;
    return w;
  endfunction

  function automatic logic [W1_BITS-1:0] mk_w1_t4();
    logic [W1_BITS-1:0] w;
    w = '0;
    w[2*(FEAT_CNT-1) +: 2] = T_NEG;
    return w;
  endfunction

  function automatic logic [W2_BITS-1:0] mk_w2_t4();
    logic [W2_BITS-1:0] w;
    w = '0;
    w[2*(4*HIDDEN_CNT) +: 2] = T_POS;
    return w;
  endfunction

  localparam logic [W1_BITS-1:0]  W1_T2 = {(HIDDEN_CNT*FEAT_CNT){T_POS}};
  localparam logic [W2_BITS-1:0]  W2_T2 = mk_w2_t2();
  localparam logic [W1_BITS-1:0]  W1_T4 = mk_w1_t4();
  localparam logic [W2_BITS-1:0]  W2_T4 = mk_w2_t4();
  localparam logic [THR_BITS-1:0] THR_Z = '0;
  localparam logic [W2_BITS-1:0]  W2_Z  = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_BITS-1:0] data = '0;
  logic [CLS_BITS-1:0] p_def, p_t2, p_t3, p_t4;
  int exp_p [4];
  int edge_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gas_id_tnn1_tnnzew u_def (.clk(clk), .rst(rst), .data(data), .prediction(p_def));
  gas_id_tnn1_tnnzew #(.W1(W1_T2), .THR(THR_Z), .W2(W2_T2))
    u_t2 (.clk(clk), .rst(rst), .data(data), .prediction(p_t2));
  gas_id_tnn1_tnnzew #(.W2(W2_Z))
    u_t3 (.clk(clk), .rst(rst), .data(data), .prediction(p_t3));
  gas_id_tnn1_tnnzew #(.W1(W1_T4), .THR(THR_Z), .W2(W2_T4))
    u_t4 (.clk(clk), .rst(rst), .data(data), .prediction(p_t4));

  function automatic int tval(input logic [1:0] code);
    if (code == 2'b01) return 1;
    if (code == 2'b11) return -1;
    return 0;
  endfunction

  // Whole-network evaluation straight from the weight tables.
  function automatic int model(input logic [W1_BITS-1:0] w1, input logic [THR_BITS-1:0] thr,
                               input logic [W2_BITS-1:0] w2, input logic [DATA_BITS-1:0] d);
    int acc;
    int sc [CLASS_CNT];
    bit hid [HIDDEN_CNT];
    int best;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      acc = 0;
      for (int f = 0; f < FEAT_CNT; f++)
        acc += tval(w1[2*(h*FEAT_CNT+f) +: 2]) * int'(d[4*f +: 4]);
      hid[h] = acc >= int'($signed(thr[ACC_BITS*h +: ACC_BITS]));
    end
    for (int c = 0; c < CLASS_CNT; c++) begin
      sc[c] = 0;
      for (int h = 0; h < HIDDEN_CNT; h++)
        sc[c] += tval(w2[2*(c*HIDDEN_CNT+h) +: 2]) * (hid[h] ? 1 : -1);
    end
    best = 0;
    for (int c = 1; c < CLASS_CNT; c++)
      if (sc[c] > sc[best]) best = c;
    return best;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else if (edge_cnt < 100000) edge_cnt <= edge_cnt + 1;
  end

  // Outputs are checked every cycle while in reset and from the final edge onward.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_def", int'(p_def), 0);
        chk("rst_t2", int'(p_t2), 0);
        chk("rst_t3", int'(p_t3), 0);
        chk("rst_t4", int'(p_t4), 0);
      end else if (edge_cnt >= STEP_DONE) begin
        chk("pred_def", int'(p_def), exp_p[0]);
        chk("pred_t2", int'(p_t2), exp_p[1]);
        chk("pred_t3", int'(p_t3), exp_p[2]);
        chk("pred_t4", int'(p_t4), exp_p[3]);
      end
    end
  end

  function automatic logic [DATA_BITS-1:0] rand_vec();
    logic [DATA_BITS-1:0] d;
    for (int f = 0; f < FEAT_CNT; f++) d[4*f +: 4] = 4'($urandom_range(0, 15));
    return d;
  endfunction

  task automatic start(input logic [DATA_BITS-1:0] d);
    @(negedge clk);
    rst = 1'b1;
    data = d;
    exp_p[0] = model(W1_DEFAULT, THR_DEFAULT, W2_DEFAULT, d);
    exp_p[1] = model(W1_T2, THR_Z, W2_T2, d);
    exp_p[2] = model(W1_DEFAULT, THR_DEFAULT, W2_Z, d);
    exp_p[3] = model(W1_T4, THR_Z, W2_T4, d);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input logic [DATA_BITS-1:0] d, input int extra);
    start(d);
    repeat (STEP_DONE + extra) @(negedge clk);
  endtask

  logic [DATA_BITS-1:0] v;

  initial begin
    repeat (3) @(negedge clk);

    v = {FEAT_CNT{4'hF}};
    chk("model_t2_allF", model(W1_T2, THR_Z, W2_T2, v), 2);
    run(v, 1);
    chk("lit_t2_allF", int'(p_t2), 2);
    chk("lit_t3_allF", int'(p_t3), 0);

    v = rand_vec();
    v[4*(FEAT_CNT-1) +: 4] = 4'd1;
    chk("model_t4_f1", model(W1_T4, THR_Z, W2_T4, v), 0);
    run(v, 1);
    chk("lit_t4_f127_1", int'(p_t4), 0);

    v = rand_vec();
    v[4*(FEAT_CNT-1) +: 4] = 4'd0;
    chk("model_t4_f0", model(W1_T4, THR_Z, W2_T4, v), 4);
    run(v, 1);
    chk("lit_t4_f127_0", int'(p_t4), 4);

    v = '0;
    run(v, 1);
    chk("lit_t2_zero", int'(p_t2), 2);
    chk("lit_t4_zero", int'(p_t4), 4);

    // Abort a run at edge 100 and restart on a different vector.
    start(rand_vec());
    repeat (100) @(negedge clk);
    run(rand_vec(), 2);

    // Hold: data wanders after completion; the prediction must not.
    run(rand_vec(), 0);
    repeat (50) begin
      data = rand_vec();
      @(negedge clk);
    end

    for (int n = 0; n < 150; n++) run(rand_vec(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
